uart_cmd_parser: RTL and testbench
==================================

# uart_cmd_parser

Frame decoder sitting directly downstream of the UART receive path. Consumes one byte per `rx_valid` strobe (driven from the UART receiver's done flag and data), assembles `SOF | CMD | LEN | PAYLOAD[LEN] | CHK` frames, verifies length and checksum, and presents each good command to project logic as a one-cycle `cmd_valid` pulse with stable, registered command and payload fields. Malformed frames are dropped and reported on error pulses.

## Interface
Parameters:
- `SOF`, 8'hAA, start-of-frame byte
- `MAX_LEN`, 8, maximum payload bytes (1..15)
- `TIMEOUT_CYCLES`, 1_000_000, inter-byte timeout (10 ms at 100 MHz); used only with `CMD_PARSER_TIMEOUT_EN`

Ports:
- `sys_clk`  in  1  system clock; one clock, all logic on rising edge
- `sys_rst`  in  1  synchronous, active-high reset
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a received byte
- `rx_data`  in  8  received byte
- `cmd_valid`  out  1  one-cycle pulse: new good frame on `cmd_*`
- `cmd_code`  out  8  CMD byte of last good frame
- `cmd_len`  out  4  LEN of last good frame
- `cmd_payload`  out  8*MAX_LEN  payload of last good frame; byte i at [8i+7:8i]; bytes ≥ `cmd_len` are zero
- `err_checksum`  out  1  one-cycle pulse: CHK mismatch
- `err_len`  out  1  one-cycle pulse: LEN > `MAX_LEN`
- `err_timeout`  out  1  one-cycle pulse: frame abandoned by timeout
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, GET_CMD, GET_LEN, GET_PAY, GET_CHK. Transitions occur only on `rx_valid` (except timeout).
- IDLE: byte == `SOF` → GET_CMD; any other byte ignored, no error.
- GET_CMD: store in staging register, start running sum = CMD → GET_LEN.
- GET_LEN: LEN > `MAX_LEN` → `err_len`, IDLE. LEN == 0 → GET_CHK. Otherwise clear staging payload, index = 0 → GET_PAY. LEN added to sum.
- GET_PAY: write byte to staging[index], add to sum, index++; after byte LEN-1 → GET_CHK. Bytes equal to `SOF` are ordinary data (no resync).
- GET_CHK: CHK must equal (CMD + LEN + Σpayload) mod 256 (8-bit wrap-around sum). Match → copy staging to `cmd_code`/`cmd_len`/`cmd_payload`, pulse `cmd_valid`. Mismatch → `err_checksum`, outputs unchanged. Either way → IDLE.
- Output fields change only on a good frame; held stable otherwise, including across errors.
- Error pulses are mutually exclusive and never coincide with `cmd_valid`.

## Timing
- Reset: state IDLE, all outputs 0 (`cmd_payload` all zero), sum/index/timeout counter cleared. Reset mid-frame discards the partial frame with no error pulse.
- Latency: `cmd_valid`, `err_checksum`, `err_len` assert in the cycle after the `rx_valid` of the deciding byte (registered outputs); `cmd_*` fields update on the same edge.
- Back-to-back `rx_valid` on consecutive cycles is accepted at full rate; the SOF of the next frame may arrive in the cycle `cmd_valid` is high.
- `busy` is registered and reflects the state after each edge.

## Configuration
- `CMD_PARSER_TIMEOUT_EN` defined: a counter clears on every `rx_valid` and increments each cycle while state ≠ IDLE; on reaching `TIMEOUT_CYCLES` (without `rx_valid` in that cycle), `err_timeout` pulses next cycle and state → IDLE, dropping the partial frame. If `rx_valid` coincides with expiry, the byte is consumed normally and the counter clears.
- Not defined: no counter is instantiated; `err_timeout` is tied to 0; a partial frame waits indefinitely.

## Test plan
- Bytes 55, AA, 01, 02, 10, 20, 33 → 55 ignored; one `cmd_valid`; `cmd_code`=01, `cmd_len`=2, `cmd_payload`[15:0]=16'h2010, upper bytes 0.
- AA, 05, 00, 05 → `cmd_valid`, `cmd_code`=05, `cmd_len`=0, payload all zero; then AA 80 02 C0 40 82 → `cmd_valid` (sum wrap 0x182 → 0x82).
- AA, 01, 02, 10, 20, 34 → `err_checksum` pulse only; `cmd_*` retain previous good-frame values.
- AA, 01, 09 (`MAX_LEN`=8) → `err_len` after the 09 byte; next AA 01 00 01 decodes normally.
- With macro, `TIMEOUT_CYCLES`=100: AA, 01, then idle → `err_timeout` pulse, `busy` low; without macro, no pulse and `busy` stays high.
- `sys_rst` asserted after AA 01 02 10 → all outputs 0, IDLE; subsequent full frame decodes correctly.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// UART command frame decoder: SOF | CMD | LEN | PAYLOAD[LEN] | CHK.
// Optional inter-byte timeout enabled by defining CMD_PARSER_TIMEOUT_EN.
module uart_cmd_parser #(
  parameter logic [7:0] SOF            = 8'hAA,
  parameter int         MAX_LEN        = 8,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 cmd_valid,
  output logic [7:0]           cmd_code,
  output logic [3:0]           cmd_len,
  output logic [8*MAX_LEN-1:0] cmd_payload,
  output logic                 err_checksum,
  output logic                 err_len,
  output logic                 err_timeout,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE, GET_CMD, GET_LEN, GET_PAY, GET_CHK
  } state_e;

  localparam logic [7:0] MaxLenB = 8'(MAX_LEN);

  state_e               state_q, state_d;
  logic [7:0]           code_q, code_d;
  logic [3:0]           len_q, len_d;
  logic [7:0]           sum_q, sum_d;
  logic [3:0]           idx_q, idx_d;
  logic [8*MAX_LEN-1:0] stg_q, stg_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic [7:0]           cmd_code_q, cmd_code_d;
  logic [3:0]           cmd_len_q, cmd_len_d;
  logic [8*MAX_LEN-1:0] cmd_payload_q, cmd_payload_d;
  logic                 err_chk_q, err_chk_d;
  logic                 err_len_q, err_len_d;
  logic                 err_tmo_q, err_tmo_d;
  logic                 busy_q, busy_d;
  logic                 tmo_expire;

`ifdef CMD_PARSER_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;

  // Inter-byte counter: cleared by any byte or while idle.
  always_comb begin
    tmo_d      = tmo_q + 32'd1;
    tmo_expire = 1'b0;
    if (rx_valid || state_q == IDLE) begin
      tmo_d = '0;
    end else if (tmo_d == 32'(TIMEOUT_CYCLES)) begin
      tmo_expire = 1'b1;
      tmo_d      = '0;
    end
  end

  // Timeout counter register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`else
  assign tmo_expire = 1'b0;
`endif

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state: advance only on a byte, or abandon on timeout.
  always_comb begin
    state_d = state_q;
    if (rx_valid) begin
      unique case (state_q)
        IDLE:    if (rx_data == SOF) state_d = GET_CMD;
        GET_CMD: state_d = GET_LEN;
        GET_LEN: begin
          if (rx_data > MaxLenB)    state_d = IDLE;
          else if (rx_data == 8'd0) state_d = GET_CHK;
          else                      state_d = GET_PAY;
        end
        GET_PAY: if (idx_q == len_q - 4'd1) state_d = GET_CHK;
        GET_CHK: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else if (tmo_expire) begin
      state_d = IDLE;
    end
  end

  // Staging datapath and registered outputs.
  always_comb begin
    code_d        = code_q;
    len_d         = len_q;
    sum_d         = sum_q;
    idx_d         = idx_q;
    stg_d         = stg_q;
    cmd_code_d    = cmd_code_q;
    cmd_len_d     = cmd_len_q;
    cmd_payload_d = cmd_payload_q;
    cmd_valid_d   = 1'b0;
    err_chk_d     = 1'b0;
    err_len_d     = 1'b0;
    err_tmo_d     = tmo_expire;
    busy_d        = (state_d != IDLE);
    if (rx_valid) begin
      unique case (state_q)
        GET_CMD: begin
          code_d = rx_data;
          sum_d  = rx_data;
          stg_d  = '0;
          len_d  = '0;
        end
        GET_LEN: begin
          sum_d = sum_q + rx_data;
          idx_d = '0;
          len_d = rx_data[3:0];
          if (rx_data > MaxLenB) err_len_d = 1'b1;
        end
        GET_PAY: begin
          sum_d = sum_q + rx_data;
          idx_d = idx_q + 4'd1;
          for (int i = 0; i < MAX_LEN; i++) begin
            if (idx_q == 4'(i)) stg_d[8*i +: 8] = rx_data;
          end
        end
        GET_CHK: begin
          if (rx_data == sum_q) begin
            cmd_valid_d   = 1'b1;
            cmd_code_d    = code_q;
            cmd_len_d     = len_q;
            cmd_payload_d = stg_q;
          end else begin
            err_chk_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      code_q        <= '0;
      len_q         <= '0;
      sum_q         <= '0;
      idx_q         <= '0;
      stg_q         <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_code_q    <= '0;
      cmd_len_q     <= '0;
      cmd_payload_q <= '0;
      err_chk_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_tmo_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      code_q        <= code_d;
      len_q         <= len_d;
      sum_q         <= sum_d;
      idx_q         <= idx_d;
      stg_q         <= stg_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_code_q    <= cmd_code_d;
      cmd_len_q     <= cmd_len_d;
      cmd_payload_q <= cmd_payload_d;
      err_chk_q     <= err_chk_d;
      err_len_q     <= err_len_d;
      err_tmo_q     <= err_tmo_d;
      busy_q        <= busy_d;
    end
  end

  assign cmd_valid    = cmd_valid_q;
  assign cmd_code     = cmd_code_q;
  assign cmd_len      = cmd_len_q;
  assign cmd_payload  = cmd_payload_q;
  assign err_checksum = err_chk_q;
  assign err_len      = err_len_q;
  assign err_timeout  = err_tmo_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser.
// Pulse counters are sampled on the falling edge.
module tb_uart_cmd_parser;

  logic        clk;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic [3:0]  cmd_len;
  logic [63:0] cmd_payload;
  logic        err_checksum;
  logic        err_len;
  logic        err_timeout;
  logic        busy;

  int checks;
  int failures;
  int n_cv, n_ec, n_el, n_et, n_multi;

  uart_cmd_parser #(
    .SOF(8'hAA),
    .MAX_LEN(8),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .cmd_valid(cmd_valid),
    .cmd_code(cmd_code),
    .cmd_len(cmd_len),
    .cmd_payload(cmd_payload),
    .err_checksum(err_checksum),
    .err_len(err_len),
    .err_timeout(err_timeout),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      n_cv += int'(cmd_valid);
      n_ec += int'(err_checksum);
      n_el += int'(err_len);
      n_et += int'(err_timeout);
      if (int'(cmd_valid) + int'(err_checksum) +
          int'(err_len) + int'(err_timeout) > 1)
        n_multi++;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_cv = 0; n_ec = 0; n_el = 0; n_et = 0; n_multi = 0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send(bytes[i]);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulses(input string tag,
                        input int cv, input int ec,
                        input int el, input int et);
    chk({tag, "_cv"}, 64'(n_cv), 64'(cv));
    chk({tag, "_ec"}, 64'(n_ec), 64'(ec));
    chk({tag, "_el"}, 64'(n_el), 64'(el));
    chk({tag, "_et"}, 64'(n_et), 64'(et));
    chk({tag, "_mx"}, 64'(n_multi), 64'd0);
  endtask

  task automatic fields(input string tag,
                        input logic [7:0] c,
                        input logic [3:0] l,
                        input logic [63:0] p);
    chk({tag, "_code"}, 64'(cmd_code), 64'(c));
    chk({tag, "_len"}, 64'(cmd_len), 64'(l));
    chk({tag, "_pay"}, cmd_payload, p);
  endtask

  initial begin
    checks = 0; failures = 0;
    rx_valid = 1'b0; rx_data = 8'h00;
    clr();
    @(negedge clk);
    do_reset();

    fields("rst", 8'h00, 4'd0, 64'h0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cv", 64'(cmd_valid), 64'd0);
    chk("rst_errs", 64'({err_checksum, err_len, err_timeout}), 64'd0);

    clr();
    frame('{8'h55, 8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33});
    pulses("f1", 1, 0, 0, 0);
    fields("f1", 8'h01, 4'd2, 64'h2010);
    chk("f1_busy", 64'(busy), 64'd0);

    clr();
    frame('{8'hAA, 8'h05, 8'h00, 8'h05});
    pulses("len0", 1, 0, 0, 0);
    fields("len0", 8'h05, 4'd0, 64'h0);

    clr();
    frame('{8'hAA, 8'h80, 8'h02, 8'hC0, 8'h40, 8'h82});
    pulses("wrap", 1, 0, 0, 0);
    fields("wrap", 8'h80, 4'd2, 64'h40C0);

    clr();
    frame('{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34});
    pulses("bad", 0, 1, 0, 0);
    fields("bad", 8'h80, 4'd2, 64'h40C0);

    clr();
    frame('{8'hAA, 8'h01, 8'h09});
    pulses("big", 0, 0, 1, 0);
    chk("big_busy", 64'(busy), 64'd0);
    fields("big", 8'h80, 4'd2, 64'h40C0);

    clr();
    frame('{8'hAA, 8'h01, 8'h00, 8'h01});
    pulses("after", 1, 0, 0, 0);
    fields("after", 8'h01, 4'd0, 64'h0);

    clr();
    frame('{8'hAA, 8'h10, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04,
            8'h05, 8'h06, 8'h07, 8'h08, 8'h3C});
    pulses("max", 1, 0, 0, 0);
    fields("max", 8'h10, 4'd8, 64'h0807060504030201);

    clr();
    frame('{8'hAA, 8'h02, 8'h01, 8'hAA, 8'hAD});
    pulses("sofdat", 1, 0, 0, 0);
    fields("sofdat", 8'h02, 4'd1, 64'hAA);

    clr();
    frame('{8'hAA, 8'h03, 8'h01, 8'h7F, 8'h83,
            8'hAA, 8'h04, 8'h00, 8'h04});
    pulses("b2b", 2, 0, 0, 0);
    fields("b2b", 8'h04, 4'd0, 64'h0);

    clr();
    send(8'hAA);
    send(8'h01);
    repeat (200) @(negedge clk);
`ifdef CMD_PARSER_TIMEOUT_EN
    pulses("tmo", 0, 0, 0, 1);
    chk("tmo_busy", 64'(busy), 64'd0);
`else
    pulses("tmo", 0, 0, 0, 0);
    chk("tmo_busy", 64'(busy), 64'd1);
`endif

    do_reset();
    clr();
    frame('{8'hAA, 8'h01, 8'h02, 8'h10});
    chk("mid_busy", 64'(busy), 64'd1);
    do_reset();
    fields("mrst", 8'h00, 4'd0, 64'h0);
    chk("mrst_busy", 64'(busy), 64'd0);
    pulses("mrst", 0, 0, 0, 0);

    clr();
    frame('{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33});
    pulses("post", 1, 0, 0, 0);
    fields("post", 8'h01, 4'd2, 64'h2010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
